zigzag_reorder: RTL

Reorders each 8x8 block of quantized coefficients from raster (row-major) order into the JPEG zig-zag scan order. It sits directly downstream of the quantizer and feeds the run-length/Huffman entropy stage. Blocks are buffered in ping-pong coefficient RAMs so that one block loads while the previous one drains, sustaining one coefficient per clock. AXI-Stream handshakes apply on both sides.

---
 rtl/zigzag_reorder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/zigzag_reorder.sv
`default_nettype none
// ============================================================================
// Module   : zigzag_reorder
// Function : Ping-pong buffered raster-to-zigzag reorder of 8x8 coefficient
//            blocks with AXI-Stream on both sides; ZIGZAG_PINGPONG_EN
//            selects two banks (overlapped load/drain), otherwise one bank.
// Revision : 1.0
// ============================================================================
module zigzag_reorder #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic              s_axis_tlast,
   input  logic              s_axis_tuser,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              m_axis_tuser,
   output logic              blk_err
);

`ifdef ZIGZAG_PINGPONG_EN
   localparam logic PINGPONG = 1'b1;
`else
   localparam logic PINGPONG = 1'b0;
`endif

   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

   typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_SEND = 1'b1} rd_state_t;

   logic [DATA_W-1:0] mem [128];
   logic [1:0]        full, full_eff, full_nx, tu;
   logic              wbank, rbank, rbank_nx, nb, started;
   logic [5:0]        wcnt, rcnt, rcnt_nx, rcnt_inc;
   rd_state_t         state, state_nx;
   logic              acc, blk_end, clr;
   logic              valid_nx, last_nx, user_nx;
   logic [DATA_W-1:0] data_nx;

   assign s_axis_tready = started & ~full[wbank];
   assign acc           = s_axis_tvalid & s_axis_tready;
   assign blk_end       = acc & (wcnt == 6'd63);
   assign nb            = PINGPONG ? ~rbank : rbank;
   assign rcnt_inc      = rcnt + 6'd1;

   // A block completing this cycle counts as full so the drain can start
   // on the same edge and the first output appears one cycle later.
   always_comb begin
      full_eff = full;
      if (blk_end) full_eff[wbank] = 1'b1;
      full_nx = full_eff;
      if (clr) full_nx[rbank] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (acc) mem[{wbank, wcnt}] <= s_axis_tdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started <= 1'b0;
         wcnt    <= 6'd0;
         wbank   <= 1'b0;
         tu      <= 2'b00;
         full    <= 2'b00;
         blk_err <= 1'b0;
      end else begin
         started <= 1'b1;
         full    <= full_nx;
         if (acc) begin
            wcnt <= wcnt + 6'd1;
            if (wcnt == 6'd0) tu[wbank] <= s_axis_tuser;
            if (blk_end) wbank <= PINGPONG ? ~wbank : 1'b0;
            if (s_axis_tlast != (wcnt == 6'd63)) blk_err <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      rcnt_nx  = rcnt;
      rbank_nx = rbank;
      valid_nx = m_axis_tvalid;
      last_nx  = m_axis_tlast;
      user_nx  = m_axis_tuser;
      data_nx  = m_axis_tdata;
      clr      = 1'b0;
      case (state)
         RD_IDLE: begin
            if (full_eff[rbank]) begin
               state_nx = RD_SEND;
               rcnt_nx  = 6'd0;
               valid_nx = 1'b1;
               last_nx  = 1'b0;
               user_nx  = tu[rbank];
               data_nx  = mem[{rbank, 6'd0}];
            end
         end
         RD_SEND: begin
            if (m_axis_tvalid && m_axis_tready) begin
               if (rcnt == 6'd63) begin
                  clr      = 1'b1;
                  rbank_nx = nb;
                  rcnt_nx  = 6'd0;
                  last_nx  = 1'b0;
                  if ((nb != rbank) && full_eff[nb]) begin
                     user_nx = tu[nb];
                     data_nx = mem[{nb, 6'd0}];
                  end else begin
                     state_nx = RD_IDLE;
                     valid_nx = 1'b0;
                     user_nx  = 1'b0;
                  end
               end else begin
                  rcnt_nx = rcnt_inc;
                  last_nx = (rcnt == 6'd62);
                  user_nx = 1'b0;
                  data_nx = mem[{rbank, ZZ[rcnt_inc]}];
               end
            end
         end
         default: state_nx = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= RD_IDLE;
         rcnt          <= 6'd0;
         rbank         <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         m_axis_tdata  <= '0;
      end else begin
         state         <= state_nx;
         rcnt          <= rcnt_nx;
         rbank         <= rbank_nx;
         m_axis_tvalid <= valid_nx;
         m_axis_tlast  <= last_nx;
         m_axis_tuser  <= user_nx;
         m_axis_tdata  <= data_nx;
      end
   end

endmodule
`default_nettype wire
